// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the CPU data-memory interface.
// Takes one load/store from the execute stage, forms the effective address,
// validates size/alignment, pulses one memory strobe, then returns the
// extended read word with a done pulse.
// Optional build macro: LSU_MISALIGN_TRAP_EN (reject misaligned accesses
// instead of force-aligning them).
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct,
  input  logic [31:0]       req_base,
  input  logic [11:0]       req_offset,
  input  logic [31:0]       req_wdata,
  output logic              done,
  output logic              err,
  output logic [31:0]       load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              signed_unsigned,
  output logic [1:0]        mem_size,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              store_q, store_d;
  logic              su_q, su_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       load_data_q, load_data_d;

  logic [31:0]       ea_full_s;
  logic [ADDR_W-1:0] ea_s;
  logic [ADDR_W-1:0] ea_final_s;
  logic              illegal_s;
  logic              misaligned_s;
  logic              reject_s;
  logic              unused_ea_s;

  // Byte/half results are sign- or zero-extended to 32 bits; words pass through.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
    logic [31:0] result;
    case (size)
      2'b01:   result = {{24{~is_unsigned & word[7]}}, word[7:0]};
      2'b10:   result = {{16{~is_unsigned & word[15]}}, word[15:0]};
      default: result = word;
    endcase
    return result;
  endfunction

  assign ea_full_s   = req_base + {{20{req_offset[11]}}, req_offset};
  assign ea_s        = ea_full_s[ADDR_W-1:0];
  // Address bits above ADDR_W are dropped: the sum wraps silently.
  assign unused_ea_s = ^ea_full_s[31:ADDR_W];

  // Classify the incoming request: illegal size code, misalignment, final address.
  always_comb begin
    illegal_s    = (req_funct[1:0] == 2'b00) ||
                   (req_funct[2] && (req_funct[1:0] == 2'b11));
    misaligned_s = 1'b0;
    if (req_funct[1:0] == 2'b10) begin
      misaligned_s = ea_s[0];
    end else if (req_funct[1:0] == 2'b11) begin
      misaligned_s = (ea_s[1:0] != 2'b00);
    end else begin
      misaligned_s = 1'b0;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    ea_final_s = ea_s;
    reject_s   = illegal_s || misaligned_s;
`else
    ea_final_s = ea_s;
    if (misaligned_s && (req_funct[1:0] == 2'b10)) begin
      ea_final_s[0] = 1'b0;
    end else if (misaligned_s) begin
      ea_final_s[1:0] = 2'b00;
    end else begin
      ea_final_s = ea_s;
    end
    reject_s = illegal_s;
`endif
  end

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    su_d        = su_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          su_d    = req_funct[2];
          size_d  = req_funct[1:0];
          addr_d  = ea_final_s;
          wdata_d = req_wdata;
          if (reject_s) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = ISSUE;
            mem_read_d  = ~req_store;
            mem_write_d = req_store;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (store_q) begin
          state_d = RESP;
          done_d  = 1'b1;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d     = RESP;
        done_d      = 1'b1;
        load_data_d = extend_load(mem_read_data, size_q, su_q);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      su_q        <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= 32'h0000_0000;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      su_q        <= su_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      done_q      <= done_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign done            = done_q;
  assign err             = err_q;
  assign load_data       = load_data_q;
  assign mem_addr        = addr_q;
  assign mem_write_data  = wdata_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign signed_unsigned = su_q;
  assign mem_size        = size_q;

endmodule
